data_mem_ctrl: RTL and testbench
================================

# data_mem_ctrl

Single-port, word-organised data memory with a request/valid handshake. It sits directly downstream of the RV32I core's memory stage. It consumes the core's data-memory request, write/read select, byte mask, ALU address and aligned store data, and returns load data plus a one-cycle `valid` pulse after a configurable access latency. The core's memory stage performs load byte/half extraction and sign extension; this block always returns the full addressed word.

## Interface
Parameters:
- `DEPTH_WORDS`, default 1024: number of 32-bit words; must be a power of two, at least 2.
- `LATENCY`, default 1: edges from acceptance to `valid`; legal range 1..15.

Ports (widths; `AW = $clog2(DEPTH_WORDS)`):
- `clk`, input, 1: single clock; all state updates on its rising edge.
- `rst`, input, 1: asynchronous, active-high reset.
- `data_mem_request`, input, 1: access request from the core.
- `data_mem_we_re`, input, 1: 1 = write (store), 0 = read (load).
- `mask_signal`, input, 4: byte-lane enables for writes; bit i selects bits [8i+7:8i]; ignored on reads.
- `alu_out_address`, input, 32: byte address; bits [1:0] are ignored.
- `store_data_out`, input, 32: lane-aligned store data.
- `load_data_in`, output, 32: read data, registered.
- `data_mem_valid`, output, 1: one-cycle completion pulse.
- `ready`, output, 1: block can accept a request this cycle.
- `access_err`, output, 1: qualifies `data_mem_valid`; the address was out of range.

## Operation
- FSM states:
  - IDLE: `ready` = 1.
  - WAIT: busy, counting down.
  - RESP: `valid` cycle; `ready` = 0.
- Acceptance: at a rising edge where state is IDLE and `data_mem_request` = 1, the block captures the address, we_re, mask and store data into holding registers. It then moves to WAIT with `cnt <= LATENCY-1`.
- WAIT:
  - If `cnt != 0`: `cnt` decrements.
  - If `cnt == 0`: the access is performed at this edge, `data_mem_valid <= 1`, and the state moves to RESP.
- RESP: at the next edge, `data_mem_valid <= 0`, `access_err <= 0`, and the state moves to IDLE.
- Word index is `addr[AW+1:2]`. The address is out of range when `addr[31:2] >= DEPTH_WORDS`.
- Write, in range: lane i of the word is replaced by `store_data[8i+7:8i]` where `mask[i]` = 1. Other lanes are unchanged. A mask of 0000 completes normally and changes nothing. `load_data_in` holds its previous value.
- Read, in range: `load_data_in <=` the full array word. It reflects all writes committed at earlier edges.
- Out of range: no array write. On a read, `load_data_in <= 0`. `access_err <= 1` together with `data_mem_valid`.
- Requests seen while `ready` = 0 are ignored, not queued. The core must hold its request until it sees `valid`. A request still high in the cycle after RESP is accepted again as a new access.
- `load_data_in` holds its value between accesses.

## Timing
- Accepting edge E0 → access performed and `valid` set at edge E(LATENCY) → `valid` cleared at E(LATENCY+1).
- For LATENCY = 1, `valid` is high in the cycle right after the accepting cycle.
- Earliest next accept is at edge E(LATENCY+2). Throughput is one access per LATENCY+2 cycles.
- `ready` is combinational from state (state == IDLE). The other outputs are registered.
- Reset values (asynchronous, immediate):
  - state IDLE, `cnt` 0.
  - `data_mem_valid` 0, `access_err` 0, `load_data_in` 0.
  - `ready` 1.
  - Array contents are not reset.
- Reset asserted mid-access (WAIT or RESP): the access is abandoned. A write not yet committed is not performed. No `valid` pulse follows reset deassertion.
- Input changes after the accepting edge have no effect on the in-flight access.

## Test plan
- Reset: assert `rst` between edges → immediately `data_mem_valid`=0, `access_err`=0, `load_data_in`=0, `ready`=1.
- LATENCY=1, write 0xDEADBEEF to 0x10 with mask 1111, then read 0x10 → `valid` one edge after each accept; read returns 0xDEADBEEF; `ready` low for 2 cycles per access.
- After the above, byte write: store 0x0000AA00 to 0x10 with mask 0010, then read 0x10 → 0xDEADAAEF.
- LATENCY=3: hold request and drive a second address while busy → only the first access completes, at E3. The second is accepted at E5 after `ready` rises.
- DEPTH_WORDS=1024, read 0x00001000 (word 1024) → `valid`=1, `access_err`=1, `load_data_in`=0. A write there leaves word 0 unchanged.
- LATENCY=3: accept a write of 0x12345678 to 0x20, then pulse `rst` after E1 → no `valid` pulse. A subsequent read of 0x20 returns the prior contents, not 0x12345678.

Source files
------------

// File: rtl/data_mem_ctrl_if.sv
// Request/response bundle between the core memory stage
// and the data memory controller.
interface data_mem_ctrl_if;
  logic        data_mem_request;
  logic        data_mem_we_re;
  logic [3:0]  mask_signal;
  logic [31:0] alu_out_address;
  logic [31:0] store_data_out;
  logic [31:0] load_data_in;
  logic        data_mem_valid;
  logic        ready;
  logic        access_err;

  modport master (
    output data_mem_request,
    output data_mem_we_re,
    output mask_signal,
    output alu_out_address,
    output store_data_out,
    input  load_data_in,
    input  data_mem_valid,
    input  ready,
    input  access_err
  );

  modport slave (
    input  data_mem_request,
    input  data_mem_we_re,
    input  mask_signal,
    input  alu_out_address,
    input  store_data_out,
    output load_data_in,
    output data_mem_valid,
    output ready,
    output access_err
  );
endinterface

// File: rtl/data_mem_ctrl.sv
// Word-organised single-port data memory with a fixed
// access latency and a one-cycle valid pulse per access.
module data_mem_ctrl #(
  parameter int DEPTH_WORDS = 1024,
  parameter int LATENCY     = 1
) (
  input logic            clk,
  input logic            rst,
  data_mem_ctrl_if.slave bus
);
  localparam int AW = $clog2(DEPTH_WORDS);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_RESP
  } state_t;

  state_t      r_state;
  state_t      w_next;
  logic [3:0]  r_cnt;
  logic [3:0]  w_cnt;
  logic [29:0] r_addr;
  logic        r_we;
  logic [3:0]  r_mask;
  logic [31:0] r_wdata;
  logic [31:0] r_load;
  logic        r_valid;
  logic        r_err;
  logic        w_accept;
  logic        w_commit;
  logic        w_oor;
  logic [AW-1:0] w_idx;

  logic [31:0] r_mem [DEPTH_WORDS];

  assign w_idx = r_addr[AW-1:0];
  assign w_oor = r_addr >= 30'(DEPTH_WORDS);

  assign bus.ready          = (r_state == S_IDLE);
  assign bus.data_mem_valid = r_valid;
  assign bus.access_err     = r_err;
  assign bus.load_data_in   = r_load;

  always_comb begin
    w_next   = r_state;
    w_cnt    = r_cnt;
    w_accept = 1'b0;
    w_commit = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (bus.data_mem_request) begin
          w_accept = 1'b1;
          w_next   = S_WAIT;
          w_cnt    = 4'(LATENCY - 1);
        end
      end
      S_WAIT: begin
        if (r_cnt == 4'd0) begin
          w_commit = 1'b1;
          w_next   = S_RESP;
        end else begin
          w_cnt = r_cnt - 4'd1;
        end
      end
      S_RESP: begin
        w_next = S_IDLE;
      end
      default: begin
        w_next = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_cnt   <= 4'd0;
      r_addr  <= '0;
      r_we    <= 1'b0;
      r_mask  <= 4'd0;
      r_wdata <= 32'd0;
      r_load  <= 32'd0;
      r_valid <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_next;
      r_cnt   <= w_cnt;
      if (w_accept) begin
        r_addr  <= bus.alu_out_address[31:2];
        r_we    <= bus.data_mem_we_re;
        r_mask  <= bus.mask_signal;
        r_wdata <= bus.store_data_out;
      end
      if (w_commit) begin
        r_valid <= 1'b1;
        r_err   <= w_oor;
        if (!r_we) begin
          r_load <= w_oor ? 32'd0 : r_mem[w_idx];
        end
      end else if (r_state == S_RESP) begin
        r_valid <= 1'b0;
        r_err   <= 1'b0;
      end
    end
  end

  // Array is not reset; reset forces IDLE so no commit fires.
  always_ff @(posedge clk) begin
    if (w_commit && r_we && !w_oor) begin
      for (int i = 0; i < 4; i++) begin
        if (r_mask[i]) begin
          r_mem[w_idx][8*i +: 8] <= r_wdata[8*i +: 8];
        end
      end
    end
  end
endmodule

// File: tb/tb_data_mem_ctrl.sv
// Bench for data_mem_ctrl: one instance at LATENCY=1 and one
// at LATENCY=3, checked through an expected-response queue.
module tb_data_mem_ctrl;
  typedef struct {
    logic        we;
    logic [3:0]  mask;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_d;
    logic        exp_e;
  } vec_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst [2];
  logic        req [2];
  logic        we  [2];
  logic [3:0]  msk [2];
  logic [31:0] adr [2];
  logic [31:0] wd  [2];
  logic [31:0] rd  [2];
  logic        vld [2];
  logic        rdy [2];
  logic        err [2];

  int lat [2] = '{1, 3};
  int n_tests = 0;
  int n_fail  = 0;

  vec_t q0 [$];
  vec_t q1 [$];
  vec_t tbl [16];

  data_mem_ctrl_if bus0 ();
  data_mem_ctrl_if bus1 ();

  assign bus0.data_mem_request = req[0];
  assign bus0.data_mem_we_re   = we[0];
  assign bus0.mask_signal      = msk[0];
  assign bus0.alu_out_address  = adr[0];
  assign bus0.store_data_out   = wd[0];
  assign rd[0]  = bus0.load_data_in;
  assign vld[0] = bus0.data_mem_valid;
  assign rdy[0] = bus0.ready;
  assign err[0] = bus0.access_err;

  assign bus1.data_mem_request = req[1];
  assign bus1.data_mem_we_re   = we[1];
  assign bus1.mask_signal      = msk[1];
  assign bus1.alu_out_address  = adr[1];
  assign bus1.store_data_out   = wd[1];
  assign rd[1]  = bus1.load_data_in;
  assign vld[1] = bus1.data_mem_valid;
  assign rdy[1] = bus1.ready;
  assign err[1] = bus1.access_err;

  data_mem_ctrl #(
    .DEPTH_WORDS(1024),
    .LATENCY    (1)
  ) dut0 (
    .clk(clk),
    .rst(rst[0]),
    .bus(bus0)
  );

  data_mem_ctrl #(
    .DEPTH_WORDS(1024),
    .LATENCY    (3)
  ) dut1 (
    .clk(clk),
    .rst(rst[1]),
    .bus(bus1)
  );

  task automatic chk(input string nm,
                     input logic [31:0] got,
                     input logic [31:0] want);
    n_tests++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s got %h want %h", nm, got, want);
    end
  endtask

  // Scoreboard: every valid pulse pops one expected response.
  always @(posedge clk) begin
    vec_t e;
    #1;
    for (int k = 0; k < 2; k++) begin
      if (vld[k]) begin
        if ((k == 0 ? q0.size() : q1.size()) == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL sb%0d unexpected valid", k);
        end else begin
          if (k == 0) e = q0.pop_front();
          else        e = q1.pop_front();
          chk($sformatf("sb%0d_data@%h", k, e.addr),
              rd[k], e.exp_d);
          chk($sformatf("sb%0d_err@%h", k, e.addr),
              32'(err[k]), 32'(e.exp_e));
        end
      end
    end
  end

  task automatic drive(input int k, input vec_t v);
    req[k] = 1'b1;
    we[k]  = v.we;
    msk[k] = v.mask;
    adr[k] = v.addr;
    wd[k]  = v.wdata;
  endtask

  task automatic scramble(input int k);
    req[k] = 1'b0;
    we[k]  = ~we[k];
    msk[k] = 4'hF;
    adr[k] = 32'hFFFF_FFF0;
    wd[k]  = 32'hA5A5_5A5A;
  endtask

  task automatic push(input int k, input vec_t v);
    if (k == 0) q0.push_back(v);
    else        q1.push_back(v);
  endtask

  task automatic do_access(input int k, input vec_t v);
    int n;
    push(k, v);
    drive(k, v);
    @(posedge clk);
    #1;
    scramble(k);
    chk("acc_rdy_busy", 32'(rdy[k]), 32'd0);
    n = 0;
    while (!vld[k] && n < 20) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("acc_latency", 32'(n), 32'(lat[k]));
    chk("acc_rdy_resp", 32'(rdy[k]), 32'd0);
    @(posedge clk);
    #1;
    chk("acc_vld_clr", 32'(vld[k]), 32'd0);
    chk("acc_rdy_idle", 32'(rdy[k]), 32'd1);
  endtask

  function automatic vec_t mk(input logic w,
                              input logic [3:0] m,
                              input logic [31:0] a,
                              input logic [31:0] d,
                              input logic [31:0] ed,
                              input logic ee);
    vec_t v;
    v.we = w; v.mask = m; v.addr = a;
    v.wdata = d; v.exp_d = ed; v.exp_e = ee;
    return v;
  endfunction

  initial begin
    vec_t v;
    tbl[0]  = mk(1, 4'hF, 32'h10, 32'hDEADBEEF, 32'h0, 0);
    tbl[1]  = mk(0, 4'h0, 32'h10, 32'h0, 32'hDEADBEEF, 0);
    tbl[2]  = mk(1, 4'h2, 32'h10, 32'h0000AA00, 32'hDEADBEEF, 0);
    tbl[3]  = mk(0, 4'hF, 32'h10, 32'h0, 32'hDEADAAEF, 0);
    tbl[4]  = mk(1, 4'hF, 32'h14, 32'h01020304, 32'hDEADAAEF, 0);
    tbl[5]  = mk(1, 4'h0, 32'h14, 32'hFFFFFFFF, 32'hDEADAAEF, 0);
    tbl[6]  = mk(0, 4'h0, 32'h14, 32'h0, 32'h01020304, 0);
    tbl[7]  = mk(1, 4'h9, 32'h14, 32'hA0B0C0D0, 32'h01020304, 0);
    tbl[8]  = mk(0, 4'h0, 32'h17, 32'h0, 32'hA00203D0, 0);
    tbl[9]  = mk(0, 4'h0, 32'h1000, 32'h0, 32'h0, 1);
    tbl[10] = mk(1, 4'hF, 32'h0, 32'h11111111, 32'h0, 0);
    tbl[11] = mk(1, 4'hF, 32'h1000, 32'h99999999, 32'h0, 1);
    tbl[12] = mk(0, 4'h0, 32'h0, 32'h0, 32'h11111111, 0);
    tbl[13] = mk(1, 4'hF, 32'hFFC, 32'hCAFEF00D, 32'h11111111, 0);
    tbl[14] = mk(0, 4'h0, 32'hFFC, 32'h0, 32'hCAFEF00D, 0);
    tbl[15] = mk(0, 4'h0, 32'hFFFFFFFC, 32'h0, 32'h0, 1);

    for (int k = 0; k < 2; k++) begin
      rst[k] = 1'b1;
      req[k] = 1'b0;
      we[k]  = 1'b0;
      msk[k] = 4'h0;
      adr[k] = 32'h0;
      wd[k]  = 32'h0;
    end
    #2;
    for (int k = 0; k < 2; k++) begin
      chk("rst_vld", 32'(vld[k]), 32'd0);
      chk("rst_err", 32'(err[k]), 32'd0);
      chk("rst_rd", rd[k], 32'd0);
      chk("rst_rdy", 32'(rdy[k]), 32'd1);
    end
    @(negedge clk);
    rst[0] = 1'b0;
    rst[1] = 1'b0;
    @(posedge clk);
    #1;

    for (int i = 0; i < 16; i++) do_access(0, tbl[i]);

    do_access(1, mk(1, 4'hF, 32'h40, 32'h0BADF00D, 32'h0, 0));
    do_access(1, mk(1, 4'hF, 32'h44, 32'h44444444, 32'h0, 0));

    // Held request while busy: second address taken only at E5.
    push(1, mk(0, 4'h0, 32'h40, 32'h0, 32'h0BADF00D, 0));
    push(1, mk(0, 4'h0, 32'h44, 32'h0, 32'h44444444, 0));
    drive(1, mk(0, 4'h0, 32'h40, 32'h0, 32'h0, 0));
    @(posedge clk);
    #1;
    adr[1] = 32'h44;
    for (int i = 1; i <= 8; i++) begin
      @(posedge clk);
      #1;
      chk($sformatf("busy_vld_E%0d", i), 32'(vld[1]),
          32'((i == 3) || (i == 8)));
      chk($sformatf("busy_rdy_E%0d", i), 32'(rdy[1]),
          32'(i == 4));
      if (i == 5) req[1] = 1'b0;
    end
    @(posedge clk);
    #1;
    chk("busy_end_rdy", 32'(rdy[1]), 32'd1);
    chk("busy_q_empty", 32'(q1.size()), 32'd0);

    do_access(1, mk(1, 4'hF, 32'h20, 32'h55AA55AA, 32'h44444444, 0));
    do_access(1, mk(0, 4'h0, 32'h20, 32'h0, 32'h55AA55AA, 0));

    // Write abandoned by reset after E1.
    drive(1, mk(1, 4'hF, 32'h20, 32'h12345678, 32'h0, 0));
    @(posedge clk);
    #1;
    req[1] = 1'b0;
    @(posedge clk);
    #1;
    rst[1] = 1'b1;
    #1;
    chk("abort_rst_vld", 32'(vld[1]), 32'd0);
    chk("abort_rst_err", 32'(err[1]), 32'd0);
    chk("abort_rst_rd", rd[1], 32'd0);
    chk("abort_rst_rdy", 32'(rdy[1]), 32'd1);
    #2;
    rst[1] = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk);
      #1;
      chk("abort_no_vld", 32'(vld[1]), 32'd0);
    end
    v = mk(0, 4'h0, 32'h20, 32'h0, 32'h55AA55AA, 0);
    do_access(1, v);

    repeat (3) @(posedge clk);
    #1;
    chk("final_q0_empty", 32'(q0.size()), 32'd0);
    chk("final_q1_empty", 32'(q1.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
